// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer.
// Contents: state encoding, default lives count, command-vector bit
// indices and the state-to-command decode used by the sequencer.
package game_pkg;

    typedef enum logic [2:0] {
        StInit      = 3'd0,
        StSetup     = 3'd1,
        StPlayFpga  = 3'd2,
        StPlayUser  = 3'd3,
        StCheck     = 3'd4,
        StPenalty   = 3'd5,
        StNextRound = 3'd6,
        StResult    = 3'd7
    } state_t;

    localparam int unsigned LIVES_DEFAULT = 3;

    // Command vector layout: {r1, r2, e1, e2, e3, e4, sel}
    localparam int unsigned CMD_W   = 7;
    localparam int unsigned CMD_R1  = 6;
    localparam int unsigned CMD_R2  = 5;
    localparam int unsigned CMD_E1  = 4;
    localparam int unsigned CMD_E2  = 3;
    localparam int unsigned CMD_E3  = 2;
    localparam int unsigned CMD_E4  = 1;
    localparam int unsigned CMD_SEL = 0;

    // Commands that depend on the state alone; e3 is input-gated elsewhere.
    function automatic logic [CMD_W-1:0] cmd_decode(input state_t s);
        logic [CMD_W-1:0] c;
        c = '0;
        case (s)
            StInit: begin
                c[CMD_R1] = 1'b1;
                c[CMD_R2] = 1'b1;
            end
            StSetup:     c[CMD_R2] = 1'b1;
            StPlayFpga:  c[CMD_E1] = 1'b1;
            StPlayUser: begin
                c[CMD_E2]  = 1'b1;
                c[CMD_SEL] = 1'b1;
            end
            StNextRound: c[CMD_E4] = 1'b1;
            StResult:    c[CMD_SEL] = 1'b1;
            default:     c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Sequencer <-> Datapath/LED bundle.
// Status from the Datapath: end_fpga, end_user, end_time, win, match.
// Commands to the Datapath: r1, r2, e1..e4, sel.
// Display outputs: lives, round, state, game_over, game_won.
// master = sequencer side, slave = Datapath/display side.
interface game_sequencer_if #(
    parameter int unsigned ROUND_W = 4
);
    logic               end_fpga;
    logic               end_user;
    logic               end_time;
    logic               win;
    logic               match;
    logic               r1;
    logic               r2;
    logic               e1;
    logic               e2;
    logic               e3;
    logic               e4;
    logic               sel;
    logic [1:0]         lives;
    logic [ROUND_W-1:0] round;
    logic [2:0]         state;
    logic               game_over;
    logic               game_won;

    modport master (
        input  end_fpga, end_user, end_time, win, match,
        output r1, r2, e1, e2, e3, e4, sel, lives, round, state, game_over, game_won
    );

    modport slave (
        output end_fpga, end_user, end_time, win, match,
        input  r1, r2, e1, e2, e3, e4, sel, lives, round, state, game_over, game_won
    );
endinterface

// File: rtl/game_sequencer_enter_edge.sv
// Enter switch synchroniser and rising-edge detector.
// Ports: clock_50 (clock), reset (async active-low), in (raw async level),
// pulse (one-cycle pulse, SYNC_STAGES+1 cycles after the rising edge).
// All flops reset to 1 so a switch held high through reset gives no pulse.
module enter_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock_50,
    input  logic reset,
    input  logic in,
    output logic pulse
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;

    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            sync_q <= '1;
            edge_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign pulse = sync_q[SYNC_STAGES-1] & ~edge_q;
endmodule

// File: rtl/game_sequencer.sv
// Game control FSM: sequences the Datapath through each round.
// Ports: clock_50, reset (async active-low), enter (raw switch), bus
// (game_sequencer_if.master: Datapath status in, commands/display out).
// Adds lives with round retry and a saturating round counter.
module game_sequencer
    import game_pkg::*;
#(
    parameter int unsigned LIVES       = LIVES_DEFAULT,
    parameter int unsigned ROUND_W     = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clock_50,
    input  logic                reset,
    input  logic                enter,
    game_sequencer_if.master    bus
);
    localparam logic [1:0] LivesInit = LIVES[1:0];

    logic               enter_pulse;
    state_t             state_q, state_d;
    logic [1:0]         lives_q, lives_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic               over_q, over_d;
    logic               won_q, won_d;
    logic               e3;
    logic [CMD_W-1:0]   cmd;

    enter_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_enter_edge (
        .clock_50 (clock_50),
        .reset    (reset),
        .in       (enter),
        .pulse    (enter_pulse)
    );

    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            state_q <= StInit;
            lives_q <= LivesInit;
            round_q <= '0;
            over_q  <= 1'b0;
            won_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            round_q <= round_d;
            over_q  <= over_d;
            won_q   <= won_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        round_d = round_q;
        over_d  = over_q;
        won_d   = won_q;
        e3      = 1'b0;
        case (state_q)
            StInit: begin
                if (enter_pulse) begin
                    state_d = StSetup;
                    lives_d = LivesInit;
                    round_d = '0;
                end
            end
            StSetup:    state_d = StPlayFpga;
            StPlayFpga: if (bus.end_fpga) state_d = StPlayUser;
            StPlayUser: begin
                // Timeout wins over a simultaneous entry; that entry is dropped.
                if (bus.end_time) begin
                    state_d = StPenalty;
                end else if (enter_pulse) begin
                    e3      = 1'b1;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (!bus.match)       state_d = StPenalty;
                else if (bus.end_user) state_d = StNextRound;
                else                  state_d = StPlayUser;
            end
            StPenalty: begin
                lives_d = lives_q - 2'd1;
                if (lives_q == 2'd1) begin
                    state_d = StResult;
                    over_d  = 1'b1;
                end else begin
                    state_d = StSetup;
                end
            end
            StNextRound: begin
                if (round_q != '1) round_d = round_q + 1'b1;
                if (bus.win) begin
                    state_d = StResult;
                    won_d   = 1'b1;
                end else begin
                    state_d = StSetup;
                end
            end
            StResult: begin
                if (enter_pulse) begin
                    state_d = StInit;
                    over_d  = 1'b0;
                    won_d   = 1'b0;
                end
            end
            default: state_d = StInit;
        endcase
    end

    assign cmd = cmd_decode(state_q);

    assign bus.r1        = cmd[CMD_R1];
    assign bus.r2        = cmd[CMD_R2];
    assign bus.e1        = cmd[CMD_E1];
    assign bus.e2        = cmd[CMD_E2];
    assign bus.e3        = e3;
    assign bus.e4        = cmd[CMD_E4];
    assign bus.sel       = cmd[CMD_SEL];
    assign bus.lives     = lives_q;
    assign bus.round     = round_q;
    assign bus.state     = state_q;
    assign bus.game_over = over_q;
    assign bus.game_won  = won_q;
endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Control FSM that sequences the game Datapath through each round: FPGA shows a sequence, user enters guesses, entries are checked, round advances, result is shown.
- Drives the Datapath command lines (r1, r2, e1–e4, sel) and consumes its status lines (end_fpga, end_user, end_time, win, match).
- Adds enter-switch synchronisation/edge detection, a lives counter with round retry, and a round counter for display.
- Sits in Topo between the switch inputs and the Datapath; LED-facing outputs feed ledr.

Parameters:
- LIVES, 3, attempts allowed before game over (1..3).
- ROUND_W, 4, width of the round counter.
- SYNC_STAGES, 2, synchroniser flops on enter (≥2).

Ports:
- clock_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- enter  in  1  raw enter switch (sw[0]), asynchronous level.
- end_fpga  in  1  Datapath: FPGA sequence display finished.
- end_user  in  1  Datapath: user has entered all elements of the round.
- end_time  in  1  Datapath: round timer expired.
- win  in  1  Datapath: last round completed.
- match  in  1  Datapath: last stored user entry matches the sequence.
- r1  out  1  clear game-level Datapath registers.
- r2  out  1  clear per-round counters (timer, user index, display index).
- e1  out  1  advance FPGA display step.
- e2  out  1  enable round timer.
- e3  out  1  store switch value as user entry; advance user index.
- e4  out  1  advance Datapath round/score.
- sel  out  1  display mux: 0 = FPGA sequence, 1 = user/result.
- lives  out  2  remaining lives.
- round  out  ROUND_W  current round, starting at 0.
- state  out  3  state encoding, for LEDs.
- game_over  out  1  high in RESULT when the game is lost.
- game_won  out  1  high in RESULT when the game is won.

Behaviour:
- enter path: SYNC_STAGES flops plus one edge flop, all reset to 1. enter_pulse is one cycle long, SYNC_STAGES+1 cycles after the rising edge. Holding enter high through reset release produces no pulse.
- States (3-bit): INIT=0, SETUP=1, PLAY_FPGA=2, PLAY_USER=3, CHECK=4, PENALTY=5, NEXT_ROUND=6, RESULT=7. Reset state is INIT.
- Command outputs are decoded from the state register; e3 is additionally gated by inputs as defined under PLAY_USER.
- Reset values: r1=1, r2=1, all other commands 0, sel=0, lives=LIVES, round=0, game_over=0, game_won=0.
- INIT: r1=1, r2=1. On enter_pulse: go to SETUP, lives←LIVES, round←0.
- SETUP: r2=1 for one cycle, then go to PLAY_FPGA.
- PLAY_FPGA: e1=1, sel=0. When end_fpga: go to PLAY_USER.
- PLAY_USER: e2=1, sel=1.
  - end_time has priority: go to PENALTY; e3 stays 0 even if enter_pulse arrives in the same cycle.
  - Otherwise, on enter_pulse: e3=1 for that cycle only, then go to CHECK.
- CHECK: single cycle; match and end_user are valid here. Timer is held (e2=0).
  - !match: go to PENALTY.
  - match and end_user: go to NEXT_ROUND.
  - match only: return to PLAY_USER. The timer is not reset; it is one budget for the whole round.
- PENALTY: one cycle, lives decrements.
  - If lives was 1 before the decrement: go to RESULT, game_over←1.
  - Otherwise: go to SETUP, which replays the same round.
- NEXT_ROUND: e4=1 for one cycle, round increments and saturates at all-ones.
  - win: go to RESULT, game_won←1.
  - Otherwise: go to SETUP.
- RESULT: sel=1, all enables 0. game_over/game_won are held until enter_pulse; then go to INIT and clear both.
- Reset asserted in any state: immediately INIT with reset values; no partial command pulses.
- Illegal encodings: none can occur with a 3-bit full encoding; the default branch goes to INIT.

Decomposition:
- Package game_pkg: state encodings, LIVES default, command bit indices, e.g. a cmd vector {r1,r2,e1,e2,e3,e4,sel}.
- Sub-module enter_edge: synchroniser plus rising-edge detector; parameter SYNC_STAGES; ports clock_50, reset, in, pulse.

Test Plan:
- Reset release with enter held high: no pulse; state=0, r1=r2=1, lives=3. Toggle enter 0→1: after 3 cycles go to SETUP, and one cycle later to PLAY_FPGA with e1=1.
- Perfect round: end_fpga, then 2 entries with match=1, end_user=1 on the second → e3 pulses twice, one NEXT_ROUND cycle with e4=1, round=1, back to SETUP.
- Mismatch: match=0 in CHECK → PENALTY, lives 3→2, SETUP; round stays 0, r2 pulses.
- Timeout with enter_pulse in the same cycle as end_time → e3=0, PENALTY, lives decrements.
- Three consecutive failures → RESULT with game_over=1, lives=0. enter_pulse → INIT, game_over=0.
- win=1 in NEXT_ROUND → RESULT, game_won=1, sel=1. Async reset mid-PLAY_USER → outputs return to reset values within the same cycle.
